// File: rtl/phivers_app_stream_fifo.sv
// Valid/ready to credit stream FIFO feeding the application-source injector.
// Optional pop/stall counters: define PHIVERS_STREAM_FIFO_STATS_EN.
module phivers_app_stream_fifo #(
  parameter int DEPTH     = 8,
  parameter int FLIT_SIZE = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [FLIT_SIZE-1:0]         in_data_i,
  input  logic                         in_last_i,
  output logic                         out_tx_o,
  input  logic                         out_credit_i,
  output logic [FLIT_SIZE-1:0]         out_data_o,
  output logic                         out_eoa_o,
`ifdef PHIVERS_STREAM_FIFO_STATS_EN
  output logic [31:0]                  flits_sent_o,
  output logic [31:0]                  stall_cycles_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] STREAM = 2'd0;
  localparam logic [1:0] DRAIN  = 2'd1;
  localparam logic [1:0] EOA    = 2'd2;

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;
  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 push;
  logic                 pop;

  assign push       = in_valid_i && in_ready_o;
  assign pop        = out_tx_o && out_credit_i;
  assign out_tx_o   = (count != '0);
  assign out_data_o = out_tx_o ? mem[rd_ptr] : '0;
  assign out_eoa_o  = (state == EOA);
  assign level_o    = count;

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CW'(1);
    else if (pop && !push)
      count_next = count - CW'(1);
  end

  always_comb begin
    state_next = state;
    unique case (state)
      STREAM: if (push && in_last_i) state_next = DRAIN;
      DRAIN:  if (count_next == '0) state_next = EOA;
      EOA:    state_next = EOA;
      default: state_next = STREAM;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push)
      mem[wr_ptr] <= in_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      state      <= STREAM;
      in_ready_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      state      <= state_next;
      // Registered ready: a full FIFO refuses a push even while popping.
      in_ready_o <= (state_next == STREAM) && (count_next != CW'(DEPTH));
    end
  end

`ifdef PHIVERS_STREAM_FIFO_STATS_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flits_sent_o   <= '0;
      stall_cycles_o <= '0;
    end else begin
      if (pop)
        flits_sent_o <= flits_sent_o + 32'd1;
      if (out_tx_o && !out_credit_i && stall_cycles_o != '1)
        stall_cycles_o <= stall_cycles_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phivers_app_stream_fifo.sv
// Directed table-driven bench for phivers_app_stream_fifo (DEPTH=8).
// Covers fill/drain, streaming wrap, full-with-pop, end-of-apps and reset.
module tb_phivers_app_stream_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_tx;
  logic        out_credit;
  logic [31:0] out_data;
  logic        out_eoa;
  logic [3:0]  level;
`ifdef PHIVERS_STREAM_FIFO_STATS_EN
  logic [31:0] flits_sent;
  logic [31:0] stall_cycles;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  phivers_app_stream_fifo #(.DEPTH(8), .FLIT_SIZE(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .in_last_i      (in_last),
    .out_tx_o       (out_tx),
    .out_credit_i   (out_credit),
    .out_data_o     (out_data),
    .out_eoa_o      (out_eoa),
`ifdef PHIVERS_STREAM_FIFO_STATS_EN
    .flits_sent_o   (flits_sent),
    .stall_cycles_o (stall_cycles),
`endif
    .level_o        (level)
  );

  typedef struct {
    logic        valid;
    logic        last;
    logic        credit;
    logic [31:0] data;
    logic        e_ready;
    logic [31:0] e_data;
    logic        e_eoa;
    logic [3:0]  e_level;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic l, logic c, logic [31:0] d,
                              logic er, logic [31:0] ed, logic ee, int lv);
    vec_t r;
    r.valid   = v;
    r.last    = l;
    r.credit  = c;
    r.data    = d;
    r.e_ready = er;
    r.e_data  = ed;
    r.e_eoa   = ee;
    r.e_level = 4'(lv);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic chk_outs(string nm, logic er, logic [31:0] ed,
                          logic ee, logic [3:0] el);
    chk({nm, " ready"}, 32'(in_ready), 32'(er));
    chk({nm, " tx"},    32'(out_tx),   32'(el != 0));
    chk({nm, " data"},  out_data,      ed);
    chk({nm, " eoa"},   32'(out_eoa),  32'(ee));
    chk({nm, " level"}, 32'(level),    32'(el));
  endtask

  task automatic apply(vec_t v, string nm);
    in_valid   = v.valid;
    in_last    = v.last;
    in_credit_set(v.credit);
    in_data    = v.data;
    @(posedge clk);
    #1;
    chk_outs(nm, v.e_ready, v.e_data, v.e_eoa, v.e_level);
  endtask

  task automatic in_credit_set(logic c);
    out_credit = c;
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_last    = 1'b0;
    in_data    = '0;
    out_credit = 1'b1;

    // idle after reset
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    // fill with credit held off, then drain in order
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, 0, 32'h10 + k, k != 8, 32'h11, 0, k));
    for (int j = 1; j <= 8; j++)
      tbl.push_back(mk(0, 0, 1, 0, 1, (j < 8) ? 32'h11 + j : 0, 0, 8 - j));
    // continuous streaming, pointers wrap
    for (int i = 0; i < 20; i++)
      tbl.push_back(mk(1, 0, 1, 32'h100 + i, 1, 32'h100 + i, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0));
    // full, valid held, one credit pulse: pop only
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1, 0, 0, 32'h20 + k, k != 8, 32'h21, 0, k));
    tbl.push_back(mk(1, 0, 1, 32'hAA, 1, 32'h22, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0, 1, 32'h22, 0, 7));
    for (int j = 1; j <= 7; j++)
      tbl.push_back(mk(0, 0, 1, 0, 1, (j < 7) ? 32'h22 + j : 0, 0, 7 - j));
    // last word, drain, sticky end-of-applications
    tbl.push_back(mk(1, 0, 0, 32'h31, 1, 32'h31, 0, 1));
    tbl.push_back(mk(1, 0, 0, 32'h32, 1, 32'h31, 0, 2));
    tbl.push_back(mk(1, 1, 0, 32'h33, 0, 32'h31, 0, 3));
    tbl.push_back(mk(1, 0, 1, 32'hEE, 0, 32'h32, 0, 2));
    tbl.push_back(mk(1, 0, 1, 32'hEE, 0, 32'h33, 0, 1));
    tbl.push_back(mk(1, 1, 1, 32'hEE, 0, 0, 1, 0));
    tbl.push_back(mk(1, 0, 1, 32'hEF, 0, 0, 1, 0));
    tbl.push_back(mk(1, 1, 0, 32'hF0, 0, 0, 1, 0));

    #12;
    chk_outs("in_reset", 0, 0, 0, 0);
`ifdef PHIVERS_STREAM_FIFO_STATS_EN
    chk("in_reset flits_sent", flits_sent, 0);
    chk("in_reset stall", stall_cycles, 0);
`endif
    #5 rst_n = 1'b1;

    foreach (tbl[i])
      apply(tbl[i], $sformatf("vec%0d", i));

`ifdef PHIVERS_STREAM_FIFO_STATS_EN
    chk("flits_sent total", flits_sent, 39);
`endif

    // fresh start, then reset in the middle of a drain
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0), "rst2 idle");
    for (int k = 1; k <= 5; k++)
      apply(mk(1, k == 5, 0, 32'h40 + k, k != 5, 32'h41, 0, k),
            $sformatf("drain_fill%0d", k));
    apply(mk(0, 0, 1, 0, 0, 32'h42, 0, 4), "drain_pop");
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_outs("mid_drain_rst", 0, 0, 0, 0);
`ifdef PHIVERS_STREAM_FIFO_STATS_EN
    chk("mid_drain_rst flits_sent", flits_sent, 0);
    chk("mid_drain_rst stall", stall_cycles, 0);
`endif
    #3 rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 1, 0, 0, 0), "post_rst idle");
    apply(mk(1, 0, 0, 32'h55, 1, 32'h55, 0, 1), "post_rst push");
    apply(mk(0, 0, 1, 0, 1, 0, 0, 0), "post_rst pop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
